// File: rtl/text_grid_pkg.sv
// Shared sizing, blank glyph and controller state encoding
// for the text grid buffer and its cell RAM.
package text_grid_pkg;

  localparam int ROWS = 7;
  localparam int COLS = 20;
  localparam int CELLS = ROWS * COLS;
  localparam logic [7:0] BLANK_GLYPH = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_grid_ram.sv
// Glyph cell store: one write port, a registered display read
// port and a combinational port feeding the scroll copy.
module text_grid_ram
  import text_grid_pkg::*;
#(
  parameter int DEPTH = CELLS,
  parameter int AW    = addr_w(CELLS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o,
  input  logic [AW-1:0] aaddr_i,
  output logic [7:0]    adata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Read sees the pre-write contents on a same-cell collision
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
  assign adata_o = mem_q[aaddr_i];

endmodule

// File: rtl/text_grid_buffer.sv
// Character-cell display buffer with sequenced clear and
// scroll-up, plus an optional bottom-row write merged into scroll.
module text_grid_buffer #(
  parameter int         ROWS        = text_grid_pkg::ROWS,
  parameter int         COLS        = text_grid_pkg::COLS,
  parameter logic [7:0] BLANK_GLYPH = text_grid_pkg::BLANK_GLYPH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_glyph,
  input  logic [3:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic       wr_en,
  input  logic       scroll,
  input  logic       clear,
  input  logic [3:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [7:0] rd_glyph,
  output logic       busy,
  output logic       drop
);

  localparam int CELLS     = ROWS * COLS;
  localparam int LAST      = CELLS - 1;
  localparam int SHIFT_END = (ROWS - 1) * COLS;
  localparam int AW        = text_grid_pkg::addr_w(CELLS);

  text_grid_pkg::state_e state_q, state_d;

  logic [AW-1:0] idx_q, idx_d;
  logic          lat_v_q, lat_v_d;
  logic [7:0]    lat_glyph_q, lat_glyph_d;
  logic [5:0]    lat_col_q, lat_col_d;
  logic          drop_q, drop_d;
  logic          rd_oob_q;

  logic          wr_ok;
  logic          rd_ok;
  logic          idx_last;
  logic          in_shift;
  logic          lat_hit;
  logic [AW-1:0] wr_cell;
  logic [AW-1:0] rd_cell;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW-1:0] ram_aaddr;
  logic [7:0]    ram_adata;
  logic [7:0]    ram_rdata;

  assign wr_ok = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign rd_ok = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

  assign wr_cell = wr_ok ?
    AW'(int'(wr_row) * COLS + int'(wr_col)) : '0;
  assign rd_cell = rd_ok ?
    AW'(int'(rd_row) * COLS + int'(rd_col)) : '0;

  assign idx_last = (idx_q == AW'(LAST));
  assign in_shift = (int'(idx_q) < SHIFT_END);

  // Latched bottom-row glyph replaces that cell's blank fill
  assign lat_hit = lat_v_q && (int'(lat_col_q) < COLS) &&
    (int'(idx_q) == SHIFT_END + int'(lat_col_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= text_grid_pkg::ST_CLEAR;
      idx_q       <= '0;
      lat_v_q     <= 1'b0;
      lat_glyph_q <= '0;
      lat_col_q   <= '0;
      drop_q      <= 1'b0;
      rd_oob_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_v_q     <= lat_v_d;
      lat_glyph_q <= lat_glyph_d;
      lat_col_q   <= lat_col_d;
      drop_q      <= drop_d;
      rd_oob_q    <= !rd_ok;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_v_d     = lat_v_q;
    lat_glyph_d = lat_glyph_q;
    lat_col_d   = lat_col_q;
    drop_d      = 1'b0;
    unique case (state_q)
      text_grid_pkg::ST_IDLE: begin
        if (clear) begin
          state_d = text_grid_pkg::ST_CLEAR;
          idx_d   = '0;
          lat_v_d = 1'b0;
        end else if (scroll) begin
          state_d     = text_grid_pkg::ST_SCROLL;
          idx_d       = '0;
          lat_v_d     = wr_en;
          lat_glyph_d = wr_glyph;
          lat_col_d   = wr_col;
        end else if (wr_en && !wr_ok) begin
          drop_d = 1'b1;
        end
      end
      text_grid_pkg::ST_CLEAR: begin
        drop_d = wr_en || scroll;
        if (idx_last) begin
          state_d = text_grid_pkg::ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      text_grid_pkg::ST_SCROLL: begin
        drop_d = wr_en || scroll;
        if (clear) begin
          state_d = text_grid_pkg::ST_CLEAR;
          idx_d   = '0;
          lat_v_d = 1'b0;
        end else if (idx_last) begin
          state_d = text_grid_pkg::ST_IDLE;
          idx_d   = '0;
          lat_v_d = 1'b0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = text_grid_pkg::ST_IDLE;
        idx_d   = '0;
        lat_v_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != text_grid_pkg::ST_IDLE);
    ram_we    = 1'b0;
    ram_waddr = idx_q;
    ram_wdata = BLANK_GLYPH;
    ram_aaddr = in_shift ? (idx_q + AW'(COLS)) : '0;
    unique case (state_q)
      text_grid_pkg::ST_IDLE: begin
        if (!clear && !scroll && wr_en && wr_ok) begin
          ram_we    = 1'b1;
          ram_waddr = wr_cell;
          ram_wdata = wr_glyph;
        end
      end
      text_grid_pkg::ST_CLEAR: begin
        ram_we = 1'b1;
      end
      text_grid_pkg::ST_SCROLL: begin
        ram_we = !clear;
        if (in_shift) begin
          ram_wdata = ram_adata;
        end else if (lat_hit) begin
          ram_wdata = lat_glyph_q;
        end
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  text_grid_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_cell),
    .rdata_o (ram_rdata),
    .aaddr_i (ram_aaddr),
    .adata_o (ram_adata)
  );

  assign rd_glyph = rd_oob_q ? BLANK_GLYPH : ram_rdata;
  assign drop     = drop_q;

endmodule

// File: tb/tb_text_grid_buffer.sv
// Self-checking bench: vector table, directed clear/scroll
// sequences and randomized traffic against a grid model.
module tb_text_grid_buffer;

  localparam int         R  = 7;
  localparam int         C  = 20;
  localparam logic [7:0] BL = 8'h80;

  typedef struct {
    logic       we;
    logic [3:0] wr;
    logic [5:0] wc;
    logic [7:0] g;
    logic [3:0] rr;
    logic [5:0] rc;
    logic       xdrop;
    logic [7:0] xrd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_glyph = '0;
  logic [3:0] wr_row = '0;
  logic [5:0] wr_col = '0;
  logic       wr_en = 1'b0;
  logic       scroll = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] rd_row = '0;
  logic [5:0] rd_col = '0;
  logic [7:0] rd_glyph;
  logic       busy;
  logic       drop;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [R][C];
  vec_t       tbl [9];

  text_grid_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .wr_glyph (wr_glyph),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_en    (wr_en),
    .scroll   (scroll),
    .clear    (clear),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_glyph (rd_glyph),
    .busy     (busy),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      step();
      n++;
    end
  endtask

  function automatic logic [7:0] model_rd(input int r, input int c);
    if (r >= R || c >= C) return BL;
    return mdl[r][c];
  endfunction

  task automatic m_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mdl[r][c] = BL;
  endtask

  // Whole rows move up one; bottom row blank, plus optional glyph
  task automatic m_scroll(input bit w, input int col,
                          input logic [7:0] g);
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C; c++)
        mdl[r][c] = mdl[r+1][c];
    for (int c = 0; c < C; c++)
      mdl[R-1][c] = BL;
    if (w && col < C) mdl[R-1][col] = g;
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        rd_row = 4'(r);
        rd_col = 6'(c);
        step();
        chk(tag, rd_glyph, mdl[r][c]);
      end
    end
  endtask

  task automatic read_at(input int r, input int c,
                         output logic [7:0] v);
    rd_row = 4'(r);
    rd_col = 6'(c);
    step();
    v = rd_glyph;
  endtask

  initial begin
    int n;
    int k;
    int rr;
    int rc;
    int wc;
    int wrow;
    bit we;
    logic [7:0] g;
    logic [7:0] xrd;
    logic [7:0] v;
    bit xdrop;

    tbl[0] = '{1'b1, 4'd2, 6'd5,  8'd10, 4'd2,  6'd5,  1'b0, 8'h80};
    tbl[1] = '{1'b0, 4'd0, 6'd0,  8'd0,  4'd2,  6'd5,  1'b0, 8'd10};
    tbl[2] = '{1'b1, 4'd7, 6'd0,  8'd20, 4'd7,  6'd0,  1'b1, 8'h80};
    tbl[3] = '{1'b1, 4'd0, 6'd20, 8'd21, 4'd0,  6'd20, 1'b1, 8'h80};
    tbl[4] = '{1'b1, 4'd0, 6'd0,  8'd33, 4'd2,  6'd5,  1'b0, 8'd10};
    tbl[5] = '{1'b1, 4'd0, 6'd0,  8'd44, 4'd0,  6'd0,  1'b0, 8'd33};
    tbl[6] = '{1'b0, 4'd0, 6'd0,  8'd0,  4'd0,  6'd0,  1'b0, 8'd44};
    tbl[7] = '{1'b1, 4'd6, 6'd19, 8'd55, 4'd15, 6'd63, 1'b0, 8'h80};
    tbl[8] = '{1'b0, 4'd0, 6'd0,  8'd0,  4'd6,  6'd19, 1'b0, 8'd55};

    m_clear();

    // Reset state
    #12;
    chk("reset_rd", rd_glyph, BL);
    chk("reset_busy", busy, 1'b1);
    chk("reset_drop", drop, 1'b0);
    step();
    reset = 1'b0;
    wait_idle(n);
    chk("reset_clear_len", n, 140);
    sweep("after_reset");

    // Single-cycle IDLE vectors
    for (int i = 0; i < 9; i++) begin
      wr_en    = tbl[i].we;
      wr_row   = tbl[i].wr;
      wr_col   = tbl[i].wc;
      wr_glyph = tbl[i].g;
      rd_row   = tbl[i].rr;
      rd_col   = tbl[i].rc;
      step();
      chk($sformatf("vec%0d_rd", i), rd_glyph, tbl[i].xrd);
      chk($sformatf("vec%0d_drop", i), drop, tbl[i].xdrop);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
      if (tbl[i].we && tbl[i].wr < R && tbl[i].wc < C)
        mdl[tbl[i].wr][tbl[i].wc] = tbl[i].g;
    end
    wr_en = 1'b0;

    // Fill rows with row+1, then scroll with a bottom-row write
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        wr_en    = 1'b1;
        wr_row   = 4'(r);
        wr_col   = 6'(c);
        wr_glyph = 8'(r + 1);
        mdl[r][c] = 8'(r + 1);
        step();
      end
    end
    scroll   = 1'b1;
    wr_en    = 1'b1;
    wr_row   = 4'd7;
    wr_col   = 6'd0;
    wr_glyph = 8'd36;
    step();
    scroll = 1'b0;
    wr_en  = 1'b0;
    chk("scroll_busy", busy, 1'b1);
    chk("scroll_drop", drop, 1'b0);
    wait_idle(n);
    chk("scroll_len", n, 140);
    m_scroll(1'b1, 0, 8'd36);
    read_at(0, 0, v);
    chk("scroll_r0", v, 8'd2);
    read_at(5, 19, v);
    chk("scroll_r5", v, 8'd7);
    read_at(6, 0, v);
    chk("scroll_r6c0", v, 8'd36);
    read_at(6, 1, v);
    chk("scroll_r6c1", v, BL);
    read_at(6, 19, v);
    chk("scroll_r6c19", v, BL);
    sweep("scroll_grid");

    // Write attempt while scrolling is dropped
    scroll = 1'b1;
    step();
    scroll = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n++;
    end
    wr_en    = 1'b1;
    wr_row   = 4'd1;
    wr_col   = 6'd1;
    wr_glyph = 8'hAA;
    step();
    n++;
    wr_en = 1'b0;
    chk("busy_wr_drop", drop, 1'b1);
    step();
    n++;
    chk("busy_wr_drop_end", drop, 1'b0);
    wait_idle(k);
    chk("scroll2_len", n + k, 140);
    m_scroll(1'b0, 0, 8'd0);
    read_at(1, 1, v);
    chk("busy_wr_cell", v, 8'd4);
    sweep("scroll2_grid");

    // Clear 50 cycles into a scroll restarts a full clear
    scroll   = 1'b1;
    wr_en    = 1'b1;
    wr_row   = 4'd3;
    wr_col   = 6'd4;
    wr_glyph = 8'd99;
    step();
    scroll = 1'b0;
    wr_en  = 1'b0;
    for (int i = 0; i < 49; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_busy", busy, 1'b1);
    chk("abort_drop", drop, 1'b0);
    n = 0;
    scroll = 1'b1;
    step();
    n++;
    scroll = 1'b0;
    chk("clear_scroll_drop", drop, 1'b1);
    clear = 1'b1;
    step();
    n++;
    clear = 1'b0;
    chk("clear_clear_nodrop", drop, 1'b0);
    wait_idle(k);
    chk("abort_clear_len", n + k, 140);
    m_clear();
    sweep("abort_grid");

    // Randomized traffic against the grid model
    for (int it = 0; it < 400; it++) begin
      k  = $urandom_range(0, 99);
      rr = $urandom_range(0, 8);
      rc = $urandom_range(0, 21);
      rd_row = 4'(rr);
      rd_col = 6'(rc);
      xrd = model_rd(rr, rc);
      if (k < 2) begin
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("rnd_clr_rd", rd_glyph, xrd);
        chk("rnd_clr_busy", busy, 1'b1);
        m_clear();
        wait_idle(n);
        chk("rnd_clr_len", n, 140);
      end else if (k < 6) begin
        we   = 1'($urandom_range(0, 1));
        wrow = $urandom_range(0, 8);
        wc   = $urandom_range(0, 21);
        g    = 8'($urandom);
        scroll   = 1'b1;
        wr_en    = we;
        wr_row   = 4'(wrow);
        wr_col   = 6'(wc);
        wr_glyph = g;
        step();
        scroll = 1'b0;
        wr_en  = 1'b0;
        chk("rnd_scr_rd", rd_glyph, xrd);
        chk("rnd_scr_drop", drop, 1'b0);
        m_scroll(we, wc, g);
        wait_idle(n);
        chk("rnd_scr_len", n, 140);
      end else begin
        we   = 1'($urandom_range(0, 1));
        wrow = $urandom_range(0, 8);
        wc   = $urandom_range(0, 21);
        g    = 8'($urandom);
        wr_en    = we;
        wr_row   = 4'(wrow);
        wr_col   = 6'(wc);
        wr_glyph = g;
        xdrop = we && (wrow >= R || wc >= C);
        step();
        wr_en = 1'b0;
        chk("rnd_rd", rd_glyph, xrd);
        chk("rnd_drop", drop, xdrop);
        if (we && wrow < R && wc < C) mdl[wrow][wc] = g;
      end
    end
    sweep("final_grid");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
